// File: rtl/jogo_desafio_memoria_core_pkg.sv
// Shared definitions for the memory game core: state codes, ROM images,
// default timing constants and the ROM lookup helper.
`default_nettype none

package jogo_desafio_memoria_core_pkg;

  // State values double as the hex code shown on the state display.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROX        = 4'h7,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hD,
    FIM_TIMEOUT = 4'hE
  } state_t;

  localparam int DEF_SHOW_ON        = 200;
  localparam int DEF_SHOW_OFF       = 100;
  localparam int DEF_TIMEOUT_CYCLES = 5000;

  // Nibble k holds word k (address 0 in the least significant nibble).
  localparam logic [63:0] ROM_A_IMG = 64'h8412_8241_8124_8421;
  localparam logic [63:0] ROM_B_IMG = 64'h8421_8421_8844_2211;

  function automatic logic [3:0] rom_word(input logic sel, input logic [3:0] addr);
    logic [63:0] img;
    img = sel ? ROM_B_IMG : ROM_A_IMG;
    return img[addr*4 +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/jogo_desafio_memoria_core_hexa7seg.sv
// Hex digit to 7-segment decoder, active-low segments ordered g..a.
`default_nettype none

module hexa7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/jogo_desafio_memoria_core.sv
// Simon-style memory game: replays a growing prefix of a one-hot ROM on the
// LEDs and checks the player's button presses against it, round by round.
`default_nettype none

module jogo_desafio_memoria_core
  import jogo_desafio_memoria_core_pkg::*;
#(
  parameter int SHOW_ON        = DEF_SHOW_ON,
  parameter int SHOW_OFF       = DEF_SHOW_OFF,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic       nivel,
  input  logic       memoria,
  output logic [3:0] leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic       db_jogadaIgualMemoria,
  output logic       db_enderecoIgualSequencia,
  output logic       db_tem_jogada,
  output logic       db_fimS,
  output logic [6:0] display_sequencia,
  output logic [6:0] display_jogada,
  output logic [6:0] display_memoria,
  output logic [6:0] display_endereco,
  output logic [6:0] display_estado
);

  state_t      r_state;
  logic [3:0]  r_addr;
  logic [3:0]  r_limit;
  logic [3:0]  r_jogada;
  logic        r_nivel;
  logic        r_mem_sel;
  logic        r_prev;
  logic [15:0] r_tmr;
  logic [15:0] r_tmo;

  logic        w_active;
  logic        w_play;
  logic [3:0]  w_rom_raw;
  logic [3:0]  w_rom;
  logic [3:0]  w_last;
  logic        w_fim;

  assign db_tem_jogada = |botoes;
  assign w_play        = db_tem_jogada & ~r_prev;
  assign w_rom_raw     = rom_word(r_mem_sel, r_addr);
  assign w_last        = r_nivel ? 4'd15 : 4'd7;
  // Debug compares are masked while idle so a freshly reset board reads all zero.
  assign w_active      = (r_state != INICIAL);
  assign w_rom         = w_active ? w_rom_raw : 4'h0;

  always_ff @(posedge clock) begin
    r_prev <= db_tem_jogada;
    if (reset) begin
      r_state   <= INICIAL;
      r_addr    <= 4'd0;
      r_limit   <= 4'd0;
      r_jogada  <= 4'd0;
      r_nivel   <= 1'b0;
      r_mem_sel <= 1'b0;
      r_prev    <= 1'b0;
      r_tmr     <= 16'd0;
      r_tmo     <= 16'd0;
    end else begin
      case (r_state)
        INICIAL: if (jogar) r_state <= PREPARA;
        PREPARA: begin
          r_addr    <= 4'd0;
          r_limit   <= 4'd0;
          r_jogada  <= 4'd0;
          r_nivel   <= nivel;
          r_mem_sel <= memoria;
          r_tmr     <= 16'd0;
          r_tmo     <= 16'd0;
          r_state   <= MOSTRA;
        end
        MOSTRA: begin
          if (r_tmr == 16'(SHOW_ON - 1)) begin
            r_tmr   <= 16'd0;
            r_state <= APAGA;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        APAGA: begin
          if (r_tmr == 16'(SHOW_OFF - 1)) begin
            r_tmr <= 16'd0;
            if (r_addr == r_limit) begin
              r_addr  <= 4'd0;
              r_tmo   <= 16'd0;
              r_state <= ESPERA;
            end else begin
              r_addr  <= r_addr + 4'd1;
              r_state <= MOSTRA;
            end
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        ESPERA: begin
          if (w_play) begin
            r_tmo   <= r_tmo + 16'd1;
            r_state <= REGISTRA;
          end else if (r_tmo >= 16'(TIMEOUT_CYCLES - 1)) begin
            r_state <= FIM_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        REGISTRA: begin
          r_jogada <= botoes;
          r_tmo    <= r_tmo + 16'd1;
          r_state  <= COMPARA;
        end
        COMPARA: begin
          if (r_jogada != w_rom_raw) begin
            r_state <= FIM_ERRO;
          end else if (r_addr != r_limit) begin
            r_addr  <= r_addr + 4'd1;
            r_tmo   <= 16'd0;
            r_state <= ESPERA;
          end else begin
            r_tmo   <= r_tmo + 16'd1;
            r_state <= PROX;
          end
        end
        PROX: begin
          if (r_limit == w_last) begin
            r_state <= FIM_ACERTO;
          end else begin
            r_limit <= r_limit + 4'd1;
            r_addr  <= 4'd0;
            r_tmr   <= 16'd0;
            r_state <= MOSTRA;
          end
        end
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) r_state <= PREPARA;
        default: r_state <= INICIAL;
      endcase
    end
  end

  assign w_fim   = (r_state == FIM_ACERTO) || (r_state == FIM_ERRO) || (r_state == FIM_TIMEOUT);
  assign pronto  = w_fim;
  assign ganhou  = (r_state == FIM_ACERTO);
  assign perdeu  = (r_state == FIM_ERRO);
  assign timeout = (r_state == FIM_TIMEOUT);

  assign leds = (r_state == MOSTRA) ? w_rom_raw :
                (r_state == ESPERA) ? botoes    : 4'h0;

  assign db_jogadaIgualMemoria     = w_active && (r_jogada == w_rom_raw);
  assign db_enderecoIgualSequencia = w_active && (r_addr == r_limit);
  assign db_fimS                   = w_active && (r_limit == w_last);

  hexa7seg u_hex_seq (.i_hex(r_limit),  .o_seg(display_sequencia));
  hexa7seg u_hex_jog (.i_hex(r_jogada), .o_seg(display_jogada));
  hexa7seg u_hex_mem (.i_hex(w_rom),    .o_seg(display_memoria));
  hexa7seg u_hex_end (.i_hex(r_addr),   .o_seg(display_endereco));
  hexa7seg u_hex_est (.i_hex(r_state),  .o_seg(display_estado));

endmodule

`default_nettype wire

// File: tb/tb_jogo_desafio_memoria_core.sv
// Directed scenario bench for the memory game core.
`default_nettype none

module tb_jogo_desafio_memoria_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic       nivel = 1'b0;
  logic       memoria = 1'b0;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, timeout;
  logic       db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS;
  logic [6:0] display_sequencia, display_jogada, display_memoria, display_endereco, display_estado;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;

  logic [3:0] rom_a [16] = '{4'd1,4'd2,4'd4,4'd8,4'd4,4'd2,4'd1,4'd8,4'd1,4'd4,4'd2,4'd8,4'd2,4'd1,4'd4,4'd8};
  logic [3:0] rom_b [16] = '{4'd1,4'd1,4'd2,4'd2,4'd4,4'd4,4'd8,4'd8,4'd1,4'd2,4'd4,4'd8,4'd1,4'd2,4'd4,4'd8};

  jogo_desafio_memoria_core dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .nivel(nivel),
    .memoria(memoria), .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .timeout(timeout), .db_jogadaIgualMemoria(db_jogadaIgualMemoria),
    .db_enderecoIgualSequencia(db_enderecoIgualSequencia), .db_tem_jogada(db_tem_jogada),
    .db_fimS(db_fimS), .display_sequencia(display_sequencia), .display_jogada(display_jogada),
    .display_memoria(display_memoria), .display_endereco(display_endereco),
    .display_estado(display_estado)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1; jogar = 1'b0; botoes = 4'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic start_game(input logic mem, input logic niv);
    memoria = mem; nivel = niv; jogar = 1'b1;
    repeat (5) @(negedge clock);
    jogar = 1'b0;
  endtask

  // Bounded wait for a state code; an expired bound counts as a failure.
  task automatic wait_state(input logic [6:0] seg, input int budget, input string name);
    int k;
    k = 0;
    while (display_estado !== seg && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (display_estado !== seg) begin
      n_fail++;
      $display("FAIL %s: state display %b, required %b", name, display_estado, seg);
    end
  endtask

  task automatic press(input logic [3:0] btn);
    botoes = btn;
    repeat (10) @(negedge clock);
    botoes = 4'h0;
    repeat (5) @(negedge clock);
  endtask

  task automatic play_round(input logic [3:0] seq [16], input int n);
    for (int i = 0; i < n; i++) begin
      wait_state(SEG_4, 6000, "wait_espera");
      press(seq[i]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) @(negedge clock);
    n_tests++; if (display_estado !== SEG_0) begin n_fail++; $display("FAIL reset_state: got %b want %b", display_estado, SEG_0); end
    n_tests++; if ({ganhou, perdeu, pronto, timeout} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {ganhou, perdeu, pronto, timeout}); end
    n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL reset_leds: got %h want 0", leds); end
    n_tests++; if ({db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS} !== 4'b0) begin
      n_fail++; $display("FAIL reset_db: got %b want 0000", {db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS}); end
    n_tests++; if ({display_sequencia, display_jogada, display_memoria, display_endereco} !== {4{SEG_0}}) begin
      n_fail++; $display("FAIL reset_displays: got %h want %h", {display_sequencia, display_jogada, display_memoria, display_endereco}, {4{SEG_0}}); end
  endtask

  task automatic test_win_rom_b();
    do_reset();
    start_game(1'b1, 1'b0);
    memoria = 1'b0;  // must not affect the game in progress
    for (int r = 1; r <= 8; r++) play_round(rom_b, r);
    repeat (5) @(negedge clock);
    n_tests++; if (display_estado !== SEG_A) begin n_fail++; $display("FAIL win_state: got %b want %b", display_estado, SEG_A); end
    n_tests++; if ({ganhou, perdeu, pronto, timeout} !== 4'b1010) begin n_fail++; $display("FAIL win_flags: got %b want 1010", {ganhou, perdeu, pronto, timeout}); end
    n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL win_leds: got %h want 0", leds); end
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    n_tests++; if (display_estado !== SEG_1) begin n_fail++; $display("FAIL restart_state: got %b want %b", display_estado, SEG_1); end
    n_tests++; if ({ganhou, pronto} !== 2'b00) begin n_fail++; $display("FAIL restart_flags: got %b want 00", {ganhou, pronto}); end
  endtask

  task automatic test_loss();
    do_reset();
    start_game(1'b1, 1'b0);
    play_round(rom_b, 1);
    play_round(rom_b, 2);
    wait_state(SEG_4, 6000, "loss_r3"); press(4'd1);
    wait_state(SEG_4, 100, "loss_p2");  press(4'd1);
    wait_state(SEG_4, 100, "loss_p3");  press(4'd4);
    n_tests++; if (display_estado !== SEG_D) begin n_fail++; $display("FAIL loss_state: got %b want %b", display_estado, SEG_D); end
    n_tests++; if ({ganhou, perdeu, pronto, timeout} !== 4'b0110) begin n_fail++; $display("FAIL loss_flags: got %b want 0110", {ganhou, perdeu, pronto, timeout}); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_game(1'b1, 1'b0);
    n_tests++; if (leds !== 4'd1 || display_estado !== SEG_2) begin n_fail++; $display("FAIL replay_led_on: leds %h state %b want 1 %b", leds, display_estado, SEG_2); end
    repeat (200) @(negedge clock);
    n_tests++; if (leds !== 4'd0 || display_estado !== SEG_3) begin n_fail++; $display("FAIL replay_led_off: leds %h state %b want 0 %b", leds, display_estado, SEG_3); end
    wait_state(SEG_E, 10000, "timeout_state");
    repeat (3) @(negedge clock);
    n_tests++; if ({ganhou, perdeu, pronto, timeout} !== 4'b0011) begin n_fail++; $display("FAIL timeout_flags: got %b want 0011", {ganhou, perdeu, pronto, timeout}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_game(1'b1, 1'b0);
    botoes = 4'd2;
    repeat (20) @(negedge clock);
    n_tests++; if (db_tem_jogada !== 1'b1) begin n_fail++; $display("FAIL tem_jogada: got %b want 1", db_tem_jogada); end
    botoes = 4'd0;
    @(negedge clock);
    n_tests++; if (display_estado !== SEG_2) begin n_fail++; $display("FAIL replay_ignore: got %b want %b", display_estado, SEG_2); end
    play_round(rom_b, 1);
    wait_state(SEG_4, 6000, "hold_r2");
    botoes = 4'd1;
    repeat (50) @(negedge clock);
    botoes = 4'd0;
    repeat (5) @(negedge clock);
    n_tests++; if (display_estado !== SEG_4) begin n_fail++; $display("FAIL hold_one_play_state: got %b want %b", display_estado, SEG_4); end
    n_tests++; if (display_endereco !== SEG_1) begin n_fail++; $display("FAIL hold_one_play_addr: got %b want %b", display_endereco, SEG_1); end
    press(4'd1);
    n_tests++; if (display_estado !== SEG_2 || display_sequencia !== SEG_2) begin
      n_fail++; $display("FAIL round3_start: state %b seq %b want %b %b", display_estado, display_sequencia, SEG_2, SEG_2); end
  endtask

  task automatic test_rom_a_16();
    do_reset();
    start_game(1'b0, 1'b1);
    for (int r = 1; r <= 15; r++) play_round(rom_a, r);
    wait_state(SEG_4, 6000, "r16_espera");
    n_tests++; if (db_fimS !== 1'b1) begin n_fail++; $display("FAIL fimS_r16: got %b want 1", db_fimS); end
    n_tests++; if (ganhou !== 1'b0) begin n_fail++; $display("FAIL early_win: got %b want 0", ganhou); end
    play_round(rom_a, 16);
    repeat (5) @(negedge clock);
    n_tests++; if (display_estado !== SEG_A || ganhou !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL win16: state %b ganhou %b timeout %b want %b 1 0", display_estado, ganhou, timeout, SEG_A); end
  endtask

  initial begin
    test_reset();
    test_win_rom_b();
    test_loss();
    test_timeout();
    test_back_to_back();
    test_rom_a_16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jogo_desafio_memoria_core.md
Name: jogo_desafio_memoria_core

Overview:
Top-level Simon-style memory game for a 1 kHz board clock. Each round n (n=1..N), the block replays the first n words of a 16x4 one-hot ROM on the LEDs, then checks the player's n button presses against them. It ends in win, loss or timeout. It also drives five 7-segment debug displays and several debug flags.

Parameters:
SHOW_ON, 200, cycles each sequence element is lit during replay
SHOW_OFF, 100, dark cycles after each replayed element
TIMEOUT_CYCLES, 5000, max cycles allowed between plays while waiting for input

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
jogar  in  1  start/restart request
botoes  in  4  one-hot player buttons
nivel  in  1  0: 8 rounds; 1: 16 rounds
memoria  in  1  ROM select (0: ROM A, 1: ROM B), sampled at start
leds  out  4  replay data / button echo
ganhou  out  1  win flag
perdeu  out  1  wrong-play flag
pronto  out  1  game finished
timeout  out  1  lost by timeout
db_jogadaIgualMemoria  out  1  registered play == ROM word
db_enderecoIgualSequencia  out  1  address == round limit
db_tem_jogada  out  1  any button pressed (OR of botoes)
db_fimS  out  1  round limit == last round
display_sequencia  out  7  hex of round limit
display_jogada  out  7  hex of registered play
display_memoria  out  7  hex of ROM output
display_endereco  out  7  hex of address
display_estado  out  7  hex of state code

Behaviour:
- Reset (synchronous, active-high) forces state INICIAL and clears all counters and registers. All outputs are 0; displays show "0".
- ROM B contents (addr 0..15): 1,1,2,2,4,4,8,8,1,2,4,8,1,2,4,8.
- ROM A contents: 1,2,4,8,4,2,1,8,1,4,2,8,2,1,4,8.
- ROM select is latched in PREPARA. Changing memoria mid-game has no effect.
- Last round index = 7 when nivel=0, 15 when nivel=1. nivel is latched in PREPARA.
- A play is the rising edge of db_tem_jogada, detected by a registered edge detector. Holding a button counts as one play.
- States and hex codes:
  - INICIAL(0) -> PREPARA on jogar.
  - PREPARA(1): address=0, limit=0, latch nivel/memoria -> MOSTRA.
  - MOSTRA(2): leds=ROM[addr] for SHOW_ON cycles -> APAGA.
  - APAGA(3): leds=0 for SHOW_OFF cycles. If addr==limit: address=0 -> ESPERA. Otherwise addr++ -> MOSTRA.
  - ESPERA(4): leds=botoes, timeout counter running. On a play -> REGISTRA. If counter reaches TIMEOUT_CYCLES -> FIM_TIMEOUT(E).
  - REGISTRA(5): latch botoes into the play register -> COMPARA.
  - COMPARA(6): on mismatch -> FIM_ERRO(D). On match with addr<limit: addr++, clear timeout counter -> ESPERA. On match with addr==limit -> PROX(7).
  - PROX(7): if limit==last round -> FIM_ACERTO(A). Otherwise limit++, addr=0 -> MOSTRA.
- Final states (A, D, E): pronto=1, leds=0. ganhou=1 only in A; perdeu=1 only in D; timeout=1 only in E. These flags hold until jogar (-> PREPARA, new game) or reset.
- Replay and input pacing: replaying round n takes n*(SHOW_ON+SHOW_OFF) cycles, at most 4800 for a 16-round game. The timeout counter runs only in ESPERA/REGISTRA/COMPARA and is cleared on entry to ESPERA from APAGA and after each correct play.
- Button presses during MOSTRA/APAGA are ignored, and the edge detector is re-armed on entry to ESPERA.
- jogar is ignored while a game is in progress.
- Simultaneous multi-button press is registered as-is and mismatches any one-hot ROM word, so it leads to FIM_ERRO.
- Counters are 4-bit. The limit never wraps past the last round.
- Display decoder: 4-bit hex to 7-segment, active-low segments g..a (0 -> 7'b1000000).

Decomposition:
- Shared package: state encodings, both ROM images, default timing constants.
- Sub-module hexa7seg: one per display, five instances.
- Datapath (counters, ROMs, registers, comparators) and the FSM stay in this module.

Test Plan:
- Reset pulse then idle 20 cycles -> state 0, all flags 0, leds=0.
- memoria=1, nivel=0, jogar for 5 cycles, then 8 rounds entered correctly (1; 1,1; 1,1,2; …; 1,1,2,2,4,4,8,8), each play a 10-cycle press with 4000-cycle gaps between rounds -> ganhou=1, pronto=1, state A, no timeout.
- Same setup, round 3 entered as 1,1,4 -> perdeu=1, pronto=1, state D right after the third play.
- Start game, press nothing for 10000 cycles -> timeout=1, pronto=1, state E. leds show 1 for 200 cycles first.
- memoria=0, nivel=1, 16 correct rounds with ROM A data -> ganhou only after round 16; db_fimS=1 during round 16.
- During replay, press buttons -> no state advance. Holding a button for 50 cycles in ESPERA counts as one play. jogar from state A restarts at PREPARA.
